// File: rtl/wait_state_memory.sv
// wait_state_memory: word-addressed single-port memory with fixed wait states and a Ready handshake.
// Rev 1.0
`default_nettype none

module wait_state_memory #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CS,
  input  logic                  WE,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] Data_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Err
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              wait_cnt;
  logic                    lat_we;
  logic                    lat_oor;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_oor;
  logic                    accept;
  logic                    enter_done;
  logic                    use_lat;
  logic                    acc_we;
  logic                    acc_oor;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    mem_wr;

  assign in_oor     = (Address >> (ADDR_WIDTH + 2)) != 32'd0;
  assign accept     = CS && (state == S_IDLE || state == S_DONE);
  assign enter_done = (state_next == S_DONE);

  // With zero wait states the access happens on the accepting edge, so bus values are used directly.
  assign use_lat  = (state == S_WAIT);
  assign acc_we   = use_lat ? lat_we   : WE;
  assign acc_oor  = use_lat ? lat_oor  : in_oor;
  assign acc_idx  = use_lat ? lat_idx  : Address[ADDR_WIDTH+1:2];
  assign acc_data = use_lat ? lat_data : Data_In;
  assign mem_wr   = RST && enter_done && acc_we && !acc_oor;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (CS) state_next = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
        else    state_next = S_IDLE;
      end
      S_WAIT:  if (wait_cnt == 4'd0) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt <= 4'd0;
      lat_we   <= 1'b0;
      lat_oor  <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
      Data_Out <= '0;
    end else begin
      if (accept) begin
        lat_we   <= WE;
        lat_oor  <= in_oor;
        lat_idx  <= Address[ADDR_WIDTH+1:2];
        lat_data <= Data_In;
        wait_cnt <= WAIT_INIT;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_done && !acc_we)
        Data_Out <= acc_oor ? '0 : mem[acc_idx];
    end
  end

  // Array contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_wr) mem[acc_idx] <= acc_data;
  end

  assign Ready = (state == S_DONE);
  assign Busy  = (state == S_WAIT);
  assign Err   = (state == S_DONE) && lat_oor;

endmodule

`default_nettype wire

// File: tb/tb_wait_state_memory.sv
// tb_wait_state_memory: randomized bench for wait_state_memory against a word-array reference model.
// Rev 1.0
`default_nettype none

module tb_wait_state_memory;

  localparam int WS = 2;

  logic        CLK;
  logic        RST;
  logic        CS, WE;
  logic [31:0] Address, Data_In, Data_Out;
  logic        Ready, Busy, Err;

  logic        cs0, we0;
  logic [31:0] addr0, din0, dout0;
  logic        ready0, busy0, err0;

  int n_tests = 0;
  int n_fail  = 0;
  int busy0_seen = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] exp_dout;
  logic [9:0]  pool [16];

  wait_state_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .Address(Address), .Data_In(Data_In),
    .Data_Out(Data_Out), .Ready(Ready), .Busy(Busy), .Err(Err)
  );

  wait_state_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST(RST), .CS(cs0), .WE(we0), .Address(addr0), .Data_In(din0),
    .Data_Out(dout0), .Ready(ready0), .Busy(busy0), .Err(err0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) if (busy0) busy0_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge on which Ready is seen, bus still carrying junk.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] data, input bit hold_cs);
    logic [31:0] a;
    logic [9:0]  idx;
    bit          oor;
    int          lat;
    int          busy_n;
    a      = addr;
    idx    = a[11:2];
    oor    = (addr >= 32'h1000);
    CS = 1'b1; WE = we; Address = addr; Data_In = data;
    lat    = 0;
    busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      lat = k;
      if (Ready) break;
      if (Busy) busy_n++;
      CS = 1'($urandom); WE = 1'($urandom); Address = $urandom; Data_In = $urandom;
    end
    if (we && !oor) ref_mem[idx] = data;
    if (!we) exp_dout = oor ? 32'd0 : ref_mem[idx];
    check("ready", {31'd0, Ready}, 32'd1);
    check("latency", lat, WS + 1);
    check("busy_cycles", busy_n, WS);
    check("busy_in_done", {31'd0, Busy}, 32'd0);
    check("err", {31'd0, Err}, {31'd0, oor});
    check("data_out", Data_Out, exp_dout);
    if (!hold_cs) begin
      CS = 1'b0; WE = 1'($urandom); Address = $urandom; Data_In = $urandom;
    end
  endtask

  task automatic idle_check();
    @(negedge CLK);
    check("idle_ready", {31'd0, Ready}, 32'd0);
    check("idle_busy", {31'd0, Busy}, 32'd0);
    check("hold_dout", Data_Out, exp_dout);
  endtask

  initial begin
    logic [31:0] a;
    RST = 1'b0; CS = 1'b0; WE = 1'b0; Address = 32'd0; Data_In = 32'd0;
    cs0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; din0 = 32'd0;
    exp_dout = 32'd0;
    repeat (3) @(negedge CLK);
    check("rst_dout", Data_Out, 32'd0);
    check("rst_ready", {31'd0, Ready}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Write then read back 0x10, including hold after Ready drops.
    txn(1'b1, 32'h0000_0010, 32'hDEADBEEF, 0);
    idle_check();
    txn(1'b0, 32'h0000_0010, 32'h0, 0);
    check("rd_0x10", Data_Out, 32'hDEADBEEF);
    idle_check();
    idle_check();

    // Preload and back-to-back reads with CS held.
    txn(1'b1, 32'h0, 32'd1, 1);
    txn(1'b1, 32'h4, 32'd2, 1);
    txn(1'b1, 32'h8, 32'd3, 0);
    idle_check();
    txn(1'b0, 32'h0, 32'h0, 1);
    check("b2b_1", Data_Out, 32'd1);
    txn(1'b0, 32'h4, 32'h0, 1);
    check("b2b_2", Data_Out, 32'd2);
    txn(1'b0, 32'h8, 32'h0, 0);
    check("b2b_3", Data_Out, 32'd3);
    idle_check();

    // Out-of-range write must not alias onto index 0.
    txn(1'b1, 32'h0000_1000, 32'h55, 0);
    txn(1'b0, 32'h0, 32'h0, 0);
    check("no_alias", Data_Out, 32'd1);
    txn(1'b0, 32'h0000_1000, 32'h0, 0);
    check("oor_read", Data_Out, 32'd0);
    idle_check();

    // Reset during WAIT aborts the write.
    txn(1'b1, 32'h20, 32'hCAFEF00D, 0);
    txn(1'b0, 32'h8, 32'h0, 0);
    CS = 1'b1; WE = 1'b1; Address = 32'h20; Data_In = 32'h12345678;
    @(negedge CLK);
    CS = 1'b0;
    check("abort_busy", {31'd0, Busy}, 32'd1);
    #2 RST = 1'b0;
    #1;
    exp_dout = 32'd0;
    check("async_dout", Data_Out, 32'd0);
    check("async_ready", {31'd0, Ready}, 32'd0);
    check("async_busy", {31'd0, Busy}, 32'd0);
    check("async_err", {31'd0, Err}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("abort_no_ready", {31'd0, Ready}, 32'd0);
    end
    RST = 1'b1;
    idle_check();
    txn(1'b0, 32'h20, 32'h0, 0);
    check("abort_old_val", Data_Out, 32'hCAFEF00D);
    idle_check();

    // Zero-wait-state instance: write then back-to-back read of 0x4.
    cs0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; din0 = 32'hA5A5A5A5;
    @(negedge CLK);
    check("ws0_wr_ready", {31'd0, ready0}, 32'd1);
    check("ws0_wr_err", {31'd0, err0}, 32'd0);
    we0 = 1'b0; din0 = 32'h0;
    @(negedge CLK);
    check("ws0_rd_ready", {31'd0, ready0}, 32'd1);
    check("ws0_rd_data", dout0, 32'hA5A5A5A5);
    cs0 = 1'b0;
    @(negedge CLK);
    check("ws0_idle_ready", {31'd0, ready0}, 32'd0);
    check("ws0_hold", dout0, 32'hA5A5A5A5);

    // Randomized traffic over a pool of initialised words plus out-of-range addresses.
    for (int i = 0; i < 16; i++) begin
      pool[i] = 10'($urandom);
      txn(1'b1, {20'd0, pool[i], 2'($urandom)}, $urandom, 1'($urandom));
    end
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 99) < 15)
        a = ($urandom_range(1, 20'hFFFFF) << 12) | 32'($urandom_range(0, 4095));
      else
        a = {20'd0, pool[$urandom_range(0, 15)], 2'($urandom)};
      txn(1'($urandom), a, $urandom, 1'($urandom));
    end
    CS = 1'b0;
    idle_check();

    check("ws0_never_busy", busy0_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wait_state_memory.md
Name: wait_state_memory

Overview:
- Word-addressed, single-port memory responder on the MIPS CPU's CS/WE/Address/data bus.
- Adds a fixed, parameterised wait-state delay and a Ready handshake, so the CPU can be run against slow memory.
- Data is split into separate in/out buses; there is no tri-state.
- Out-of-range accesses are flagged.

Parameters:
- ADDR_WIDTH, 10, log2 of depth in 32-bit words (1024 words).
- DATA_WIDTH, 32, word width.
- WAIT_STATES, 2, extra cycles between request acceptance and completion. Legal range 0..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- CS  input  1  chip select; request present when 1.
- WE  input  1  1 = write, 0 = read; sampled with CS.
- Address  input  32  byte address; word index = Address[ADDR_WIDTH+1:2]; Address[1:0] ignored.
- Data_In  input  DATA_WIDTH  write data; sampled with CS.
- Data_Out  output  DATA_WIDTH  read data; valid while Ready=1 on a read; held until the next read completes.
- Ready  output  1  one-cycle completion pulse.
- Busy  output  1  1 while a request is in progress (WAIT state).
- Err  output  1  pulses with Ready when the completed request was out of range.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; Data_Out=0; Ready=0; Busy=0; Err=0; wait counter=0.
  - The memory array is NOT cleared.
- States:
  - IDLE:
    - CS=1 is accepted: latch WE, word index, Data_In, and range flag.
    - WAIT_STATES>0: go to WAIT with counter=WAIT_STATES-1.
    - WAIT_STATES=0: go to DONE.
  - WAIT:
    - Busy=1. Counter decrements each cycle.
    - When counter=0: go to DONE on the next edge.
    - CS/WE/Address/Data_In are ignored; the latched copies are used.
  - DONE:
    - Ready=1 for exactly this cycle; Err=range flag.
    - CS=1 in DONE is accepted as a new request, with the same transitions as IDLE (back-to-back). Otherwise go to IDLE.
- Latency: Ready asserts exactly WAIT_STATES+1 cycles after the accepting edge.
- Access timing: the array write and the Data_Out register load both occur on the edge entering DONE.
- Writes: store the latched data at the latched index.
  - Data_Out is unchanged by writes.
- Reads: Data_Out = array[latched index].
  - Out-of-range read: Data_Out=0.
- Out of range: Address[31:ADDR_WIDTH+2] ≠ 0.
  - The write is suppressed and the array is unchanged.
  - Err=1 together with Ready.
- Write followed by read of the same word: the read returns the new data. Accesses are serialised, so there is no hazard.
- CS dropped during WAIT: the request still completes. There is no cancel.
- Reset mid-WAIT: the request is aborted, no write occurs, and Ready is never asserted for it.
- Ready, Busy, and Err are registered (decoded from state) and are never high in IDLE.

Test Plan (WAIT_STATES=2 unless stated):
- Reset check: assert RST=0 mid-test -> Data_Out=0, Ready=0, Busy=0, Err=0 immediately (asynchronous); state returns to IDLE.
- Write/read:
  - CS=1, WE=1, Address=0x0000_0010, Data_In=0xDEADBEEF for one cycle -> Busy=1 for 2 cycles, then Ready=1 for 1 cycle (3 cycles after acceptance), Err=0.
  - Then read 0x10 -> Data_Out=0xDEADBEEF with Ready; the value is held after Ready drops.
- Back-to-back: hold CS=1 across reads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3) -> Ready pulses every 3 cycles; Data_Out sequence 1, 2, 3.
- Out of range:
  - Write 0x0000_1000 (index bit beyond ADDR_WIDTH) with 0x55 -> Ready=1, Err=1.
  - Read 0x0 afterwards -> original contents; no aliasing.
  - Read 0x1000 -> Data_Out=0, Err=1.
- Abort and sampling:
  - Start write 0x20 = 0x12345678, assert RST=0 during WAIT -> no Ready; read 0x20 after reset -> the old value is unchanged.
  - Change Address/Data_In during WAIT -> the latched values are used.
- WAIT_STATES=0 build: write then read 0x4 = 0xA5A5A5A5 -> Ready one cycle after each accepting edge; Busy never asserts; readback correct.
